// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the instruction stage sequencer and the main control decoder:
// stage codes, opcode constants and the opcode-class enumeration.
package stage_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'b000,
        ST_ID  = 3'b001,
        ST_EX  = 3'b010,
        ST_MEM = 3'b011,
        ST_WB  = 3'b100
    } stage_e;

    typedef enum logic [2:0] {
        CLS_ALU,      // IF-ID-EX-WB
        CLS_LOAD,     // LW, LW.POI: IF-ID-EX-MEM-WB
        CLS_STORE,    // SW, CALL:   IF-ID-EX-MEM
        CLS_BRANCH,   // 0010xx:     IF-ID-EX
        CLS_JMP,      // JMP:        IF-ID
        CLS_STACK,    // RET, PUSH:  IF-ID-MEM
        CLS_POP,      // POP:        IF-ID-MEM-WB
        CLS_ILLEGAL   // undefined opcode, dropped after ID
    } op_class_e;

    localparam logic [5:0] OP_ALU_LAST = 6'b000100;
    localparam logic [5:0] OP_LW       = 6'b000101;
    localparam logic [5:0] OP_LW_POI   = 6'b000110;
    localparam logic [5:0] OP_SW       = 6'b000111;
    localparam logic [3:0] OP_BR_HI    = 4'b0010;
    localparam logic [5:0] OP_JMP      = 6'b001100;
    localparam logic [5:0] OP_CALL     = 6'b001101;
    localparam logic [5:0] OP_RET      = 6'b001110;
    localparam logic [5:0] OP_PUSH     = 6'b001111;
    localparam logic [5:0] OP_POP      = 6'b010000;

endpackage

// File: rtl/stage_sequencer_op_class_decode.sv
// Combinational opcode classifier: maps a 6-bit opcode onto the stage-path class.
module op_class_decode
    import stage_sequencer_pkg::*;
(
    input  logic [5:0] op_code,
    output op_class_e  op_class
);

    // Priority chain over the opcode map; anything not listed is illegal.
    always_comb begin
        op_class = CLS_ILLEGAL;
        if (op_code <= OP_ALU_LAST) begin
            op_class = CLS_ALU;
        end else if (op_code == OP_LW || op_code == OP_LW_POI) begin
            op_class = CLS_LOAD;
        end else if (op_code == OP_SW || op_code == OP_CALL) begin
            op_class = CLS_STORE;
        end else if (op_code[5:2] == OP_BR_HI) begin
            op_class = CLS_BRANCH;
        end else if (op_code == OP_JMP) begin
            op_class = CLS_JMP;
        end else if (op_code == OP_RET || op_code == OP_PUSH) begin
            op_class = CLS_STACK;
        end else if (op_code == OP_POP) begin
            op_class = CLS_POP;
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks IF/ID/EX/MEM/WB per opcode class,
// arbitrates the shared memory handshake and keeps cycle/retire counters.
module stage_sequencer
    import stage_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  op_code,
    input  logic        mem_ready,
    output logic [2:0]  next_state,
    output logic        mem_req,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        halted,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    stage_e      state_q, state_d;
    op_class_e   class_q, class_d;
    op_class_e   id_class;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic [31:0] cycle_cnt_q;
    logic [31:0] instret_cnt_q;
    logic        mem_grant;

    op_class_decode u_decode (
        .op_code  (op_code),
        .op_class (id_class)
    );

    // Memory request and park status are decoded from the stage register; run only
    // gates the fetch request, and nothing is requested while reset is held.
    assign mem_req   = !rst && ((state_q == ST_IF && run) || state_q == ST_MEM);
    assign halted    = !rst && state_q == ST_IF && !run;
    assign mem_grant = mem_req && mem_ready;

    assign next_state  = state_q;
    assign instr_done  = done_q;
    assign illegal_op  = illegal_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

    // Next-stage selection; ID uses the live classification, later stages the latched class.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_IF: begin
                if (mem_grant) state_d = ST_ID;
            end
            ST_ID: begin
                class_d = id_class;
                case (id_class)
                    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH: state_d = ST_EX;
                    CLS_STACK, CLS_POP:                       state_d = ST_MEM;
                    CLS_JMP: begin
                        state_d = ST_IF;
                        done_d  = 1'b1;
                    end
                    default: begin
                        state_d   = ST_IF;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_EX: begin
                case (class_q)
                    CLS_ALU:             state_d = ST_WB;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default: begin
                        state_d = ST_IF;
                        done_d  = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_grant) begin
                    if (class_q == CLS_LOAD || class_q == CLS_POP) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_IF;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_IF;
                done_d  = 1'b1;
            end
            default: state_d = ST_IF;
        endcase
    end

    // Stage, latched class and one-cycle retire/illegal pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IF;
            class_q   <= CLS_ALU;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // Free-running cycle counter and retired-instruction counter, both wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (done_d) instret_cnt_q <= instret_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios plus randomized traffic,
// all compared against a path-table reference model.
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [5:0]  op_code;
    logic        mem_ready;
    logic [2:0]  next_state;
    logic        mem_req;
    logic        instr_done;
    logic        illegal_op;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    stage_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .op_code     (op_code),
        .mem_ready   (mem_ready),
        .next_state  (next_state),
        .mem_req     (mem_req),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .halted      (halted),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: current stage code, remaining path stages, expected pulses/counters.
    int          m_stage = 0;
    int          m_rest  = 0;
    bit          m_done  = 1'b0;
    bit          m_ill   = 1'b0;
    logic [31:0] m_cyc   = 32'd0;
    logic [31:0] m_ret   = 32'd0;
    logic [31:0] c0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Stages following ID for each opcode, packed low nibble first (0 ends the path); -1 = illegal.
    function automatic int path_code(input logic [5:0] op);
        int o;
        o = int'(op);
        if (o <= 4)                 return 'h42;   // EX, WB
        if (o == 5 || o == 6)       return 'h432;  // EX, MEM, WB
        if (o == 7 || o == 13)      return 'h32;   // EX, MEM
        if (o >= 8 && o <= 11)      return 'h2;    // EX
        if (o == 12)                return 0;      // nothing after ID
        if (o == 14 || o == 15)     return 'h3;    // MEM
        if (o == 16)                return 'h43;   // MEM, WB
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit rn, input logic [5:0] op, input bit rdy);
        bit req;
        if (r) begin
            m_stage = 0; m_rest = 0; m_done = 0; m_ill = 0;
            m_cyc = 32'd0; m_ret = 32'd0;
            return;
        end
        m_cyc  = m_cyc + 32'd1;
        m_done = 0;
        m_ill  = 0;
        req = (m_stage == 0 && rn) || m_stage == 3;
        if ((m_stage == 0 || m_stage == 3) && !(req && rdy)) return;
        if (m_stage == 0) begin
            m_stage = 1;
            return;
        end
        if (m_stage == 1) begin
            m_rest = path_code(op);
            if (m_rest < 0) begin
                m_stage = 0;
                m_ill   = 1;
                return;
            end
        end
        if (m_rest == 0) begin
            m_stage = 0;
            m_done  = 1;
            m_ret   = m_ret + 32'd1;
        end else begin
            m_stage = m_rest & 'hF;
            m_rest  = m_rest >> 4;
        end
    endtask

    task automatic check_outputs(input bit r, input bit rn);
        chk("next_state", 32'(next_state), 32'(m_stage));
        chk("mem_req", 32'(mem_req), (!r && ((m_stage == 0 && rn) || m_stage == 3)) ? 32'd1 : 32'd0);
        chk("halted", 32'(halted), (!r && m_stage == 0 && !rn) ? 32'd1 : 32'd0);
        chk("instr_done", 32'(instr_done), 32'(m_done));
        chk("illegal_op", 32'(illegal_op), 32'(m_ill));
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("instret_cnt", instret_cnt, m_ret);
    endtask

    // One clock cycle: apply inputs, check current outputs, clock, advance the model.
    task automatic cyc(input bit r, input bit rn, input logic [5:0] op, input bit rdy);
        rst = r; run = rn; op_code = op; mem_ready = rdy;
        #1;
        check_outputs(r, rn);
        @(posedge clk);
        model_step(r, rn, op, rdy);
        #1;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; op_code = 6'd0; mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        model_step(1'b1, 1'b0, 6'd0, 1'b0);
        #1;
        cyc(1, 0, 6'd0, 0);
        chk("rst_state", 32'(next_state), 32'd0);
        chk("rst_cnt", cycle_cnt, 32'd0);

        // ALU instruction: 0,1,2,4,0 with retire on return to IF
        chk("s1_st0", 32'(next_state), 32'd0);
        cyc(0, 1, 6'd1, 1); chk("s1_st1", 32'(next_state), 32'd1);
        cyc(0, 1, 6'd1, 1); chk("s1_st2", 32'(next_state), 32'd2);
        cyc(0, 1, 6'd1, 1); chk("s1_st3", 32'(next_state), 32'd4);
        cyc(0, 1, 6'd1, 1); chk("s1_st4", 32'(next_state), 32'd0);
        chk("s1_done", 32'(instr_done), 32'd1);
        chk("s1_ret", instret_cnt, 32'd1);

        // LW with three not-ready cycles in MEM
        cyc(1, 0, 6'd0, 0);
        c0 = cycle_cnt;
        cyc(0, 1, 6'd5, 1);
        cyc(0, 1, 6'd5, 1);
        cyc(0, 1, 6'd5, 1); chk("s2_mem", 32'(next_state), 32'd3);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 6'd5, 0); chk("s2_hold", 32'(next_state), 32'd3);
        end
        cyc(0, 1, 6'd5, 1); chk("s2_wb", 32'(next_state), 32'd4);
        cyc(0, 1, 6'd5, 1); chk("s2_if", 32'(next_state), 32'd0);
        chk("s2_len", cycle_cnt - c0, 32'd8);
        chk("s2_ret", instret_cnt, 32'd1);

        // undefined opcode dropped after ID
        cyc(0, 1, 6'd63, 1); chk("s3_id", 32'(next_state), 32'd1);
        cyc(0, 1, 6'd63, 1); chk("s3_if", 32'(next_state), 32'd0);
        chk("s3_ill", 32'(illegal_op), 32'd1);
        chk("s3_nodone", 32'(instr_done), 32'd0);
        cyc(0, 0, 6'd63, 1); chk("s3_ill_off", 32'(illegal_op), 32'd0);
        chk("s3_ret", instret_cnt, 32'd1);

        // run dropped during EX of SW
        cyc(1, 0, 6'd0, 0);
        cyc(0, 1, 6'd7, 1);
        cyc(0, 1, 6'd7, 1); chk("s4_ex", 32'(next_state), 32'd2);
        cyc(0, 0, 6'd7, 1); chk("s4_mem", 32'(next_state), 32'd3);
        cyc(0, 0, 6'd7, 1); chk("s4_if", 32'(next_state), 32'd0);
        chk("s4_done", 32'(instr_done), 32'd1);
        chk("s4_halt", 32'(halted), 32'd1);
        chk("s4_noreq", 32'(mem_req), 32'd0);
        cyc(0, 0, 6'd7, 1); chk("s4_park", 32'(next_state), 32'd0);
        cyc(0, 1, 6'd7, 1); chk("s4_resume", 32'(next_state), 32'd1);

        // reset during a MEM wait of POP
        cyc(1, 0, 6'd0, 0);
        cyc(0, 1, 6'd16, 1);
        cyc(0, 1, 6'd16, 1); chk("s5_mem", 32'(next_state), 32'd3);
        cyc(0, 1, 6'd16, 0);
        cyc(1, 1, 6'd16, 0); chk("s5_st", 32'(next_state), 32'd0);
        chk("s5_cyc", cycle_cnt, 32'd0);
        chk("s5_ret", instret_cnt, 32'd0);
        chk("s5_nodone", 32'(instr_done), 32'd0);
        cyc(0, 1, 6'd16, 1); chk("s5_refetch", 32'(next_state), 32'd1);

        // cycle counter wrap
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_q;
        m_cyc = 32'hFFFF_FFFF;
        chk("wrap_pre", cycle_cnt, 32'hFFFF_FFFF);
        cyc(0, 1, 6'd16, 1);
        chk("wrap", cycle_cnt, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit          r, rn, rdy;
            logic [5:0]  op;
            r   = ($urandom % 100) == 0;
            rn  = ($urandom % 8) != 0;
            rdy = ($urandom % 3) != 0;
            op  = (($urandom % 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 16));
            cyc(r, rn, op, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  fetch enable; 0 parks the core in IF.
- op_code  in  6  opcode field from the instruction register.
- mem_ready  in  1  shared memory completed the current access this cycle.
- next_state  out  3  current stage code driven to the main control decoder: IF=000, ID=001, EX=010, MEM=011, WB=100.
- mem_req  out  1  shared memory access requested this cycle.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when an undefined opcode is dropped.
- halted  out  1  parked in IF with run=0.
- cycle_cnt  out  32  free-running cycle counter.
- instret_cnt  out  32  retired-instruction counter.
REQ-002 The block SHALL use one clock (clk) and a synchronous, active-high reset (rst).

Function
REQ-003 next_state SHALL be a registered stage; all other outputs SHALL be registered or decoded only from registered state.
REQ-004 op_code SHALL be classified at the end of ID and latched into an internal class register; every transition after ID SHALL use the latched class, never live op_code.
REQ-005 The stage paths by opcode class SHALL be:
- ALU (000000-000100): IF-ID-EX-WB.
- LW, LW.POI (000101, 000110): IF-ID-EX-MEM-WB.
- SW (000111), CALL (001101): IF-ID-EX-MEM.
- Branch (0010xx): IF-ID-EX.
- JMP (001100): IF-ID.
- RET (001110), PUSH (001111): IF-ID-MEM.
- POP (010000): IF-ID-MEM-WB.
- Every path SHALL return to IF after its last stage.
REQ-006 An opcode outside REQ-005 SHALL cause ID->IF, a one-cycle illegal_op pulse on that transition, and no instr_done.
REQ-007 mem_req SHALL be 1 in IF when run=1, and in MEM; it SHALL be 0 in every other case.
REQ-008 IF and MEM SHALL hold while mem_req=1 and mem_ready=0; the stage SHALL advance on the cycle following a cycle with mem_req=1 and mem_ready=1.
REQ-009 ID, EX and WB SHALL each last exactly one cycle.
REQ-010 mem_ready SHALL be ignored when mem_req=0.
REQ-011 In IF with run=0, the block SHALL stay in IF with mem_req=0 and halted=1; halted SHALL be 0 in every other case.
REQ-012 run falling mid-instruction SHALL NOT interrupt that instruction; the block SHALL park at the next IF.
REQ-013 instr_done SHALL pulse for one cycle, coincident with the transition from an instruction's last stage to IF.
REQ-014 instret_cnt SHALL increment by 1 on each instr_done pulse.
REQ-015 cycle_cnt SHALL increment every cycle rst=0; both counters SHALL wrap from FFFF_FFFF to 0.
REQ-016 Minimum latencies with mem_ready=1 continuously SHALL be: ALU 4, LW 5, SW 4, branch 3, JMP 2, RET/PUSH 3, POP 4 cycles.

Reset
REQ-017 On rst=1 at a clock edge, the block SHALL set: next_state=IF, class register=ALU, mem_req=0, instr_done=0, illegal_op=0, halted=0, cycle_cnt=0, instret_cnt=0.
REQ-018 rst asserted in any stage, including a MEM wait, SHALL abort the instruction without an instr_done pulse; fetch SHALL restart in IF on the first cycle after rst=0.

Structure
REQ-019 Stage codes, opcode constants and the opcode-class enumeration SHALL reside in a shared package imported by this block and the main control decoder.
REQ-020 Opcode classification SHALL be a combinational sub-module op_class_decode (op_code in, class out); the state register, counters and pulse logic SHALL remain in stage_sequencer.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset then run=1, mem_ready=1, op_code=000001 -> next_state 0,1,2,4,0; instr_done at cycle 4; instret_cnt=1.
- LW (000101) with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles, 8 cycles total, WB follows, instret_cnt=1.
- Opcode 111111 -> IF, ID, IF; illegal_op=1 for one cycle; instret_cnt unchanged.
- run dropped during EX of SW (000111) -> MEM, then IF with halted=1, mem_req=0; run=1 resumes fetch.
- rst pulsed during a MEM wait of POP (010000) -> next_state=0, counters=0, no instr_done.
- cycle_cnt forced to FFFF_FFFF -> reads 0000_0000 on the next cycle.
